uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receiver with an internal baud/oversample tick generator and 3-sample majority-vote bit recovery. It supports runtime parity (none/even/odd), 1 or 2 stop bits, break detection, and false-start rejection. Received words, each tagged with its error flags, are buffered in a show-ahead FIFO with a valid/ready read port and a sticky overrun flag. It replaces the fixed-width RX top, which had no buffering and no break handling, in the UART subsystem.

Parameters:
DATAWIDTH, 8, data bits per frame (legal 5..9), LSB first on the line
OVERSAMPLING, 16, ticks per bit period (even, >=8)
DIVWIDTH, 12, width of baud divisor
FIFO_DEPTH, 4, entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
div  in  DIVWIDTH  clk cycles per oversample tick (0 treated as 1)
par_en  in  1  parity bit present
par_type  in  1  0=even, 1=odd
two_stop  in  1  1=two stop bits
rx_in  in  1  serial line, asynchronous, idle high
rx_data  out  DATAWIDTH  head-of-FIFO data
rx_perr  out  1  head word parity error
rx_ferr  out  1  head word framing error
rx_brk  out  1  head word is a break
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer pop; pop occurs when rx_valid&&rx_ready
rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
rx_done  out  1  one-clk pulse per completed frame (including dropped frames)
overrun  out  1  sticky; set when a frame completes while FIFO is full
ovr_clr  in  1  clears overrun (set has priority if both occur in the same cycle)

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, tick counter 0, synchroniser flops reset to 1.
- rx_in passes through a 2-flop synchroniser; all logic uses the synchronised value rxs.
- Tick generator: 1-clk tick when the counter reaches max(div,1)-1, then the counter wraps to 0. The counter free-runs except that it is zeroed on start detection so that phase is aligned.
- Sample counter sc counts ticks within a bit, 0..OVERSAMPLING-1. The bit value is the majority of rxs at sc = OS/2-1, OS/2, OS/2+1, and is resolved on the tick where sc = OS/2+1 (mid-bit).
- On start detection, par_en, par_type and two_stop are latched into shadow registers; config changes mid-frame have no effect.
- FSM states and transitions:
  - IDLE -> START on the first clk with rxs==0.
  - START: if the mid-bit vote is 1, this is a false start -> IDLE. Otherwise continue counting to the end of the bit -> DATA.
  - DATA: shift in DATAWIDTH bits LSB first, each voted at mid-bit, each bit taking OVERSAMPLING ticks. Then go to PARITY if parity is enabled, else to STOP.
  - PARITY: perr = (XOR of data ^ parity bit) != par_type.
  - STOP: vote at mid-bit; a 0 sets ferr. If two_stop, go to STOP2 at the end of the bit. Otherwise the frame completes at the mid-bit of STOP.
  - STOP2: vote at mid-bit, ORed into ferr; the frame completes at mid-bit.
  - Completion: write {brk,ferr,perr,data} to the FIFO and pulse rx_done in the same cycle. Go to IDLE, or to BRKWAIT if brk.
  - brk = data==0 && (no parity || parity bit==0) && the first stop vote==0. brk implies ferr=1. In two_stop mode, brk is judged on the first stop bit and STOP2 is still sampled.
  - BRKWAIT: stay until rxs==1, then go to IDLE.
- Early return to IDLE at stop mid-bit is intentional; it allows resync on back-to-back frames.
- FIFO (show-ahead):
  - rx_data, rx_perr, rx_ferr and rx_brk reflect the head entry whenever rx_valid=1; their values are don't-care when empty.
  - A write into an empty FIFO makes rx_valid=1 on the next clk.
  - Push when full and no pop: the word is dropped, overrun is set, and the FIFO is unchanged.
  - Push and pop in the same cycle (including when full): both are performed, count is unchanged, and there is no overrun.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH; rx_count ranges 0..FIFO_DEPTH.
- Reset mid-frame aborts the frame with nothing pushed and clears the FIFO and overrun.

Test Plan:
- DIV=2, OS=16 (32 clk/bit), 8N1, send 0xB3 -> one rx_done; rx_data=0xB3, perr=ferr=brk=0, rx_valid=1, rx_count=1.
- 8E1 send 0x81 with parity bit 1 (wrong) -> rx_data=0x81, rx_perr=1; then send the same frame with parity bit 0 -> rx_perr=0. For 8O1, send 0x81 with parity 1 -> rx_perr=0.
- 8N1 send 0x5A with stop=0 -> rx_ferr=1, brk=0. In 8N2 mode, send 0x5A with second stop=0 -> rx_ferr=1.
- Glitch: rx_in low for 6 clk then high -> FSM returns to IDLE, no rx_done, rx_count stays 0. A subsequent valid 0x3C frame is received correctly.
- Break: hold rx_in low for 12 bit times, then high -> one entry with data=0x00, brk=1, ferr=1. FSM stays in BRKWAIT until rx_in goes high; the next frame 0xA5 is received correctly.
- Overrun: rx_ready=0, send 0x11,0x22,0x33,0x44,0x55 -> rx_count=4, overrun=1, 5 rx_done pulses. Then read with rx_ready=1 -> 0x11,0x22,0x33,0x44 in order, then rx_valid=0. Assert ovr_clr -> overrun=0. Apply reset mid-frame -> all outputs 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bit recovery, parity/stop/break
// checking, and a show-ahead FIFO of received words tagged with their error flags.
module uart_rx_fifo #(
  parameter int DATAWIDTH    = 8,
  parameter int OVERSAMPLING = 16,
  parameter int DIVWIDTH     = 12,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIVWIDTH-1:0]         div,
  input  logic                        par_en,
  input  logic                        par_type,
  input  logic                        two_stop,
  input  logic                        rx_in,
  output logic [DATAWIDTH-1:0]        rx_data,
  output logic                        rx_perr,
  output logic                        rx_ferr,
  output logic                        rx_brk,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        rx_done,
  output logic                        overrun,
  input  logic                        ovr_clr
);

  localparam int SCW = $clog2(OVERSAMPLING);
  localparam int BIW = $clog2(DATAWIDTH);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int EW  = DATAWIDTH + 3;

  localparam logic [SCW-1:0] SC_S0   = SCW'(OVERSAMPLING / 2 - 1);
  localparam logic [SCW-1:0] SC_S1   = SCW'(OVERSAMPLING / 2);
  localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLING / 2 + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLING - 1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(DATAWIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_STOP2,
    S_BRKWAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                 r_sync1;
  logic                 r_rxs;
  logic [DIVWIDTH-1:0]  r_divCnt;
  logic [DIVWIDTH-1:0]  w_divMax;
  logic                 w_tick;
  logic [SCW-1:0]       r_sc;
  logic                 w_midTick;
  logic                 w_endTick;
  logic                 r_s0;
  logic                 r_s1;
  logic                 w_vote;
  logic [DATAWIDTH-1:0] r_shift;
  logic [BIW-1:0]       r_bitIdx;
  logic                 r_parBit;
  logic                 r_stop1;
  logic                 r_parEn;
  logic                 r_parType;
  logic                 r_twoStop;
  logic                 w_startDet;
  logic                 w_done;
  logic                 w_stopVote;
  logic                 w_brk;
  logic                 w_ferr;
  logic                 w_perr;
  logic [EW-1:0]        w_entry;

  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_overrun;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_rxs   <= r_sync1;
    end
  end

  // A divisor of 0 behaves as 1; >= keeps the counter bounded if div shrinks at runtime.
  assign w_divMax = (div == '0) ? '0 : div - DIVWIDTH'(1);
  assign w_tick   = (r_divCnt >= w_divMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divCnt <= '0;
    end else if (w_startDet || w_tick) begin
      r_divCnt <= '0;
    end else begin
      r_divCnt <= r_divCnt + DIVWIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sc <= '0;
    end else if (w_startDet) begin
      r_sc <= '0;
    end else if (w_tick && r_state != S_IDLE && r_state != S_BRKWAIT) begin
      r_sc <= (r_sc == SC_LAST) ? '0 : r_sc + SCW'(1);
    end
  end

  assign w_midTick = w_tick && (r_sc == SC_MID);
  assign w_endTick = w_tick && (r_sc == SC_LAST);
  assign w_vote    = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_shift   <= '0;
      r_bitIdx  <= '0;
      r_parBit  <= 1'b0;
      r_stop1   <= 1'b1;
      r_parEn   <= 1'b0;
      r_parType <= 1'b0;
      r_twoStop <= 1'b0;
    end else begin
      if (w_tick && r_sc == SC_S0) r_s0 <= r_rxs;
      if (w_tick && r_sc == SC_S1) r_s1 <= r_rxs;
      if (w_startDet) begin
        r_parEn   <= par_en;
        r_parType <= par_type;
        r_twoStop <= two_stop;
        r_bitIdx  <= '0;
      end
      if (r_state == S_DATA && w_midTick) r_shift <= {w_vote, r_shift[DATAWIDTH-1:1]};
      if (r_state == S_DATA && w_endTick) r_bitIdx <= r_bitIdx + BIW'(1);
      if (r_state == S_PARITY && w_midTick) r_parBit <= w_vote;
      if (r_state == S_STOP && w_midTick) r_stop1 <= w_vote;
    end
  end

  // Break is judged on the first stop bit even when a second one follows.
  assign w_stopVote = (r_state == S_STOP) ? w_vote : r_stop1;
  assign w_brk      = (r_shift == '0) && (!r_parEn || !r_parBit) && !w_stopVote;
  assign w_ferr     = !w_stopVote || ((r_state == S_STOP2) && !w_vote);
  assign w_perr     = r_parEn && ((^r_shift ^ r_parBit) != r_parType);
  assign w_entry    = {w_brk, w_ferr, w_perr, r_shift};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_startDet = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rxs) begin
          w_next     = S_START;
          w_startDet = 1'b1;
        end
      end
      S_START: begin
        if (w_midTick && w_vote) w_next = S_IDLE;
        else if (w_endTick) w_next = S_DATA;
      end
      S_DATA: begin
        if (w_endTick && r_bitIdx == BI_LAST) w_next = r_parEn ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_endTick) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_midTick && !r_twoStop) begin
          w_done = 1'b1;
          w_next = w_brk ? S_BRKWAIT : S_IDLE;
        end else if (w_endTick && r_twoStop) begin
          w_next = S_STOP2;
        end
      end
      S_STOP2: begin
        if (w_midTick) begin
          w_done = 1'b1;
          w_next = w_brk ? S_BRKWAIT : S_IDLE;
        end
      end
      S_BRKWAIT: begin
        if (r_rxs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A simultaneous pop frees the head slot, so a push into a full FIFO still succeeds.
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop  = rx_valid && rx_ready;
  assign w_push = w_done && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_entry;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_done && w_full && !w_pop) r_overrun <= 1'b1;
      else if (ovr_clr) r_overrun <= 1'b0;
    end
  end

  assign {rx_brk, rx_ferr, rx_perr, rx_data} = r_mem[r_rptr];
  assign rx_valid = (r_count != '0);
  assign rx_count = r_count;
  assign rx_done  = w_done;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table of frames, hand-written corner sequences,
// and randomized frames checked against a frame-level reference model with a queue FIFO.
module tb_uart_rx_fifo;

  localparam int DW     = 8;
  localparam int OS     = 16;
  localparam int DIVW   = 12;
  localparam int DEPTH  = 4;
  localparam int DIVV   = 2;
  localparam int BITCLK = OS * DIVV;
  localparam int NV     = 9;

  logic                   clk;
  logic                   rst;
  logic [DIVW-1:0]        div;
  logic                   par_en;
  logic                   par_type;
  logic                   two_stop;
  logic                   rx_in;
  logic [DW-1:0]          rx_data;
  logic                   rx_perr;
  logic                   rx_ferr;
  logic                   rx_brk;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [$clog2(DEPTH):0] rx_count;
  logic                   rx_done;
  logic                   overrun;
  logic                   ovr_clr;

  int assertCount = 0;
  int failCount   = 0;
  int doneCount   = 0;

  logic [DW+2:0] expQ[$];
  logic          expOvr;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       pe, pt, ts, pb, s1, s2;
    logic       ePerr, eFerr, eBrk;
  } vec_t;

  vec_t vecs[NV];

  uart_rx_fifo #(
    .DATAWIDTH(DW), .OVERSAMPLING(OS), .DIVWIDTH(DIVW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .div(div), .par_en(par_en), .par_type(par_type),
    .two_stop(two_stop), .rx_in(rx_in), .rx_data(rx_data), .rx_perr(rx_perr),
    .rx_ferr(rx_ferr), .rx_brk(rx_brk), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_count(rx_count), .rx_done(rx_done), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rx_done) doneCount++;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected word {brk, ferr, perr, data} from the line-level rules of a frame.
  function automatic logic [DW+2:0] modelWord(input logic [7:0] d, input logic pe, input logic pt,
                                              input logic ts, input logic pb, input logic s1,
                                              input logic s2);
    logic perr, brk, ferr;
    perr = pe && ((($countones(d) + int'(pb)) % 2) != int'(pt));
    brk  = (d == 8'h00) && (!pe || !pb) && !s1;
    ferr = !s1 || (ts && !s2) || brk;
    return {brk, ferr, perr, d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic setVec(input int i, input string n, input logic [7:0] d, input logic pe,
                        input logic pt, input logic ts, input logic pb, input logic s1,
                        input logic s2, input logic ep, input logic ef, input logic eb);
    vecs[i].name = n;  vecs[i].data = d;
    vecs[i].pe = pe;   vecs[i].pt = pt;   vecs[i].ts = ts;
    vecs[i].pb = pb;   vecs[i].s1 = s1;   vecs[i].s2 = s2;
    vecs[i].ePerr = ep; vecs[i].eFerr = ef; vecs[i].eBrk = eb;
  endtask

  task automatic sendBit(input logic b, input int nclk);
    rx_in = b;
    repeat (nclk) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt,
                               input logic ts, input logic pb, input logic s1, input logic s2);
    logic [DW+2:0] w;
    par_en = pe; par_type = pt; two_stop = ts;
    sendBit(1'b0, BITCLK);
    for (int i = 0; i < DW; i++) sendBit(d[i], BITCLK);
    if (pe) sendBit(pb, BITCLK);
    sendBit(s1, BITCLK);
    if (ts) sendBit(s2, BITCLK);
    sendBit(1'b1, 2 * BITCLK);
    w = modelWord(d, pe, pt, ts, pb, s1, s2);
    if (expQ.size() < DEPTH) expQ.push_back(w);
    else expOvr = 1'b1;
  endtask

  task automatic popOne();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    if (expQ.size() > 0) void'(expQ.pop_front());
  endtask

  task automatic popHead(input string name);
    if (expQ.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s_model: actual=empty required=entry", name);
    end else begin
      checkOutput({name, "_valid"}, 32'(rx_valid), 32'd1);
      checkOutput({name, "_data"}, 32'(rx_data), 32'(expQ[0][DW-1:0]));
      checkOutput({name, "_flags"}, 32'({rx_brk, rx_ferr, rx_perr}), 32'(expQ[0][DW+2:DW]));
      popOne();
    end
  endtask

  initial begin
    int d0;
    logic [7:0] rd;
    logic rpe, rpt, rts, rpb, rs1, rs2;
    logic [7:0] ovrData[5];

    rst = 1'b1; div = DIVW'(DIVV); par_en = 1'b0; par_type = 1'b0; two_stop = 1'b0;
    rx_in = 1'b1; rx_ready = 1'b0; ovr_clr = 1'b0; expOvr = 1'b0;
    ovrData[0] = 8'h11; ovrData[1] = 8'h22; ovrData[2] = 8'h33; ovrData[3] = 8'h44;
    ovrData[4] = 8'h55;

    setVec(0, "8N1_B3",      8'hB3, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    setVec(1, "8E1_81_bad",  8'h81, 1, 0, 0, 1, 1, 1, 1, 0, 0);
    setVec(2, "8E1_81_good", 8'h81, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    setVec(3, "8O1_81_good", 8'h81, 1, 1, 0, 1, 1, 1, 0, 0, 0);
    setVec(4, "8N1_5A_stop", 8'h5A, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    setVec(5, "8N2_5A_stp2", 8'h5A, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    setVec(6, "8E1_00_good", 8'h00, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    setVec(7, "8N1_00_brk",  8'h00, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    setVec(8, "8O2_FF_good", 8'hFF, 1, 1, 1, 1, 1, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_count", 32'(rx_count), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_done", 32'(rx_done), 32'd0);
    checkOutput("rst_data", 32'(rx_data), 32'd0);
    checkOutput("rst_flags", 32'({rx_brk, rx_ferr, rx_perr}), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      d0 = doneCount;
      applyStimulus(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].ts, vecs[i].pb,
                    vecs[i].s1, vecs[i].s2);
      checkOutput({vecs[i].name, "_done"}, 32'(doneCount - d0), 32'd1);
      checkOutput({vecs[i].name, "_count"}, 32'(rx_count), 32'd1);
      checkOutput({vecs[i].name, "_valid"}, 32'(rx_valid), 32'd1);
      checkOutput({vecs[i].name, "_data"}, 32'(rx_data), 32'(vecs[i].data));
      checkOutput({vecs[i].name, "_perr"}, 32'(rx_perr), 32'(vecs[i].ePerr));
      checkOutput({vecs[i].name, "_ferr"}, 32'(rx_ferr), 32'(vecs[i].eFerr));
      checkOutput({vecs[i].name, "_brk"}, 32'(rx_brk), 32'(vecs[i].eBrk));
      popOne();
      checkOutput({vecs[i].name, "_drained"}, 32'(rx_count), 32'd0);
    end

    // Short low glitch must be rejected as a false start.
    d0 = doneCount;
    sendBit(1'b0, 6);
    sendBit(1'b1, 3 * BITCLK);
    checkOutput("glitch_done", 32'(doneCount - d0), 32'd0);
    checkOutput("glitch_count", 32'(rx_count), 32'd0);
    applyStimulus(8'h3C, 0, 0, 0, 0, 1, 1);
    checkOutput("after_glitch_done", 32'(doneCount - d0), 32'd1);
    popHead("after_glitch");

    // Line held low for 12 bit times: exactly one break word, then wait for idle.
    par_en = 1'b0; two_stop = 1'b0;
    d0 = doneCount;
    sendBit(1'b0, 12 * BITCLK);
    checkOutput("brk_done", 32'(doneCount - d0), 32'd1);
    checkOutput("brk_count", 32'(rx_count), 32'd1);
    checkOutput("brk_data", 32'(rx_data), 32'h00);
    checkOutput("brk_brk", 32'(rx_brk), 32'd1);
    checkOutput("brk_ferr", 32'(rx_ferr), 32'd1);
    sendBit(1'b1, 2 * BITCLK);
    popOne();
    applyStimulus(8'hA5, 0, 0, 0, 0, 1, 1);
    checkOutput("after_brk_done", 32'(doneCount - d0), 32'd2);
    popHead("after_brk");

    for (int n = 0; n < 24; n++) begin
      rd  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      rpe = 1'($urandom_range(0, 1));
      rpt = 1'($urandom_range(0, 1));
      rts = 1'($urandom_range(0, 1));
      rpb = 1'(($countones(rd) + int'(rpt)) % 2) ^ ($urandom_range(0, 3) == 0);
      rs1 = ($urandom_range(0, 4) != 0);
      rs2 = ($urandom_range(0, 4) != 0);
      d0 = doneCount;
      applyStimulus(rd, rpe, rpt, rts, rpb, rs1, rs2);
      checkOutput("rand_done", 32'(doneCount - d0), 32'd1);
      popHead("rand");
    end

    // Five frames into a 4-deep FIFO with no reads.
    d0 = doneCount;
    for (int i = 0; i < 5; i++) applyStimulus(ovrData[i], 0, 0, 0, 0, 1, 1);
    checkOutput("ovr_done", 32'(doneCount - d0), 32'd5);
    checkOutput("ovr_count", 32'(rx_count), 32'(expQ.size()));
    checkOutput("ovr_flag", 32'(overrun), 32'(expOvr));
    for (int i = 0; i < 4; i++) popHead("ovr_read");
    checkOutput("ovr_empty", 32'(rx_valid), 32'(expQ.size() != 0));
    checkOutput("ovr_sticky", 32'(overrun), 32'(expOvr));
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    expOvr  = 1'b0;
    checkOutput("ovr_clr", 32'(overrun), 32'(expOvr));

    // Fill and overrun again, then reset part-way through another frame.
    for (int i = 0; i < 5; i++) applyStimulus(ovrData[i], 0, 0, 0, 0, 1, 1);
    checkOutput("pre_rst_flag", 32'(overrun), 32'(expOvr));
    sendBit(1'b0, BITCLK);
    sendBit(1'b1, BITCLK);
    sendBit(1'b0, BITCLK / 2);
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    expQ.delete();
    expOvr = 1'b0;
    checkOutput("midrst_valid", 32'(rx_valid), 32'd0);
    checkOutput("midrst_count", 32'(rx_count), 32'd0);
    checkOutput("midrst_overrun", 32'(overrun), 32'd0);
    checkOutput("midrst_done", 32'(rx_done), 32'd0);
    checkOutput("midrst_data", 32'(rx_data), 32'd0);
    checkOutput("midrst_flags", 32'({rx_brk, rx_ferr, rx_perr}), 32'd0);
    rst = 1'b0;
    d0 = doneCount;
    sendBit(1'b1, 3 * BITCLK);
    checkOutput("postrst_done", 32'(doneCount - d0), 32'd0);
    checkOutput("postrst_valid", 32'(rx_valid), 32'd0);
    applyStimulus(8'h96, 0, 0, 0, 0, 1, 1);
    popHead("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
